// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid buffer: controller state encoding,
// occupancy width and the state-to-occupancy mapping.
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/skid_ctrl.sv
// Control FSM for the skid buffer: tracks how many words are held and
// produces load enables plus the registered handshake outputs.
module skid_ctrl
    import skid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             load_main,
    output logic             load_skid,
    output logic             sel_skid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OCC_W-1:0] occupancy
);

    state_t state;
    state_t state_next;
    logic   in_fire;
    logic   out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Handshake outputs are flops loaded from the next state, so in_ready
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != TWO);
            out_valid <= (state_next != EMPTY);
            occupancy <= occ_of(state_next);
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) state_next = ONE;
                end
                ONE: begin
                    if (in_fire && !out_fire)      state_next = TWO;
                    else if (!in_fire && out_fire) state_next = EMPTY;
                end
                TWO: begin
                    if (out_fire) state_next = ONE;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Flush suppresses data loads so a word offered alongside it is never captured.
    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: begin
                    load_main = in_fire;
                end
                ONE: begin
                    load_main = in_fire & out_fire;
                    load_skid = in_fire & ~out_fire;
                end
                TWO: begin
                    load_main = out_fire;
                    sel_skid  = 1'b1;
                end
                default: begin
                    load_main = 1'b0;
                end
            endcase
        end
    end

    a_no_skid_when_full: assert property (@(posedge clk) disable iff (rst)
        (state == TWO) |-> !load_skid);

    a_occ_in_range: assert property (@(posedge clk) disable iff (rst)
        occupancy != 2'd3);

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered ready/valid on both sides, with the
// head word always presented straight from the main data register.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int n = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;
    logic         load_main;
    logic         load_skid;
    logic         sel_skid;

    skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .load_main (load_main),
        .load_skid (load_skid),
        .sel_skid  (sel_skid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .occupancy (occupancy)
    );

    // Main holds its last value whenever no load occurs, so out_data never goes X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= sel_skid ? skid_q : in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: n, default 16, data width in bits.
REQ-002 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 FLUSH  input  1  synchronous clear of all buffered entries.
REQ-005 IN_VALID  input  1  upstream presents a word on IN_DATA.
REQ-006 IN_READY  output  1  buffer accepts a word this cycle; driven directly from a flop.
REQ-007 IN_DATA  input  n  upstream word.
REQ-008 OUT_VALID  output  1  OUT_DATA holds a valid word; driven directly from a flop.
REQ-009 OUT_READY  input  1  downstream consumes the word this cycle.
REQ-010 OUT_DATA  output  n  head word; driven directly from the main data register.
REQ-011 OCCUPANCY  output  2  number of held words (0, 1 or 2).

Function
REQ-012 An input transfer (in-fire) SHALL occur on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-013 An output transfer (out-fire) SHALL occur on a rising edge where OUT_VALID=1 and OUT_READY=1.
REQ-014 The state machine SHALL have three states: EMPTY (0 words), ONE (main register valid) and TWO (main and skid registers valid).
REQ-015 EMPTY: in-fire loads main with IN_DATA and moves to ONE; otherwise stays in EMPTY.
REQ-016 ONE, in-fire and out-fire: main loads IN_DATA; stays in ONE.
REQ-017 ONE, in-fire only: skid loads IN_DATA; moves to TWO.
REQ-018 ONE, out-fire only: moves to EMPTY.
REQ-019 ONE, neither transfer: holds state and data.
REQ-020 TWO, out-fire: main loads skid; moves to ONE.
REQ-021 TWO, no out-fire: holds state and data.
REQ-022 In TWO, IN_READY=0, so no in-fire is possible.
REQ-023 Output decodes: IN_READY=1 in EMPTY and ONE. OUT_VALID=1 in ONE and TWO. OCCUPANCY = 0/1/2 for EMPTY/ONE/TWO.
REQ-024 Latency: a word accepted in EMPTY SHALL appear on OUT_DATA, with OUT_VALID=1, one cycle after its in-fire edge.
REQ-025 Sustained throughput with IN_VALID=1 and OUT_READY=1 SHALL be one word per cycle.
REQ-026 Ordering SHALL be strictly FIFO; no word is dropped or duplicated.
REQ-027 FLUSH=1 SHALL force EMPTY on the next edge and override any simultaneous in-fire or out-fire.
REQ-028 During FLUSH, data registers need not clear; OUT_VALID=0 and IN_READY=1 after the edge.
REQ-029 OUT_DATA while OUT_VALID=0 is don't-care for consumers, but SHALL hold its last value (no X after reset).

Reset
REQ-030 RESET=1 SHALL immediately, without waiting for a clock edge, force: state=EMPTY, OUT_VALID=0, IN_READY=1, OCCUPANCY=0, main=0, skid=0.
REQ-031 RESET asserted mid-operation SHALL discard all held words; the first edge after deassertion behaves as EMPTY.
REQ-032 RESET SHALL take priority over FLUSH and over all transfers.

Structure
REQ-033 A shared package skid_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the occupancy width constant.
REQ-034 The control FSM SHALL be a sub-module, skid_ctrl, producing the load enables for main and skid, the main-select (IN_DATA or skid), and the registered IN_READY/OUT_VALID.
REQ-035 The data registers SHALL stay in skid_buffer.
REQ-036 No combinational path SHALL exist from OUT_READY to IN_READY.

Verification (n=16)
REQ-037 Reset: assert RESET between edges -> OUT_VALID=0, IN_READY=1, OCCUPANCY=0, OUT_DATA=16'h0000 before the next edge.
REQ-038 Single word: IN_DATA=16'h8000 with IN_VALID=1 for one cycle, OUT_READY=0 -> next cycle OUT_VALID=1, OUT_DATA=8000, OCCUPANCY=1.
REQ-039 Backpressure: push 16'h0001 then 16'h0002 with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0; then raise OUT_READY -> outputs 0001 then 0002 in order, then OUT_VALID=0.
REQ-040 Streaming: 8 words 16'h0010..16'h0017, IN_VALID=1 and OUT_READY=1 throughout -> one word out per cycle, in order, OCCUPANCY stays at 1.
REQ-041 Flush: in TWO holding 0001/0002, pulse FLUSH with IN_VALID=1 and IN_DATA=0003 -> next cycle OCCUPANCY=0 and 0003 is not captured.
REQ-042 Mid-operation reset: in TWO, assert RESET asynchronously -> OUT_VALID=0 immediately; after release, push 16'h00AA -> emerges alone one cycle later.
